instr_fetch: RTL and testbench

//   Fetch stage directly upstream of the combinational instruction memory.

---
 rtl/instr_fetch_if.sv | 36 +++
 rtl/instr_fetch.sv | 119 +++++++++++
 tb/tb_instr_fetch.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: the instruction-memory read port and the IF/ID
// valid/ready handshake toward decode. The fetch stage uses the master view;
// memory plus decode together form the slave view.
`ifndef INSTR_MEM_WIDTH
`define INSTR_MEM_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

interface instr_fetch_if #(
  parameter int PC_W    = 32,
  parameter int ADDR_W  = `INSTR_MEM_WIDTH,
  parameter int INSTR_W = `INSTR_WIDTH
);
  // Instruction memory (combinational read)
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_re;
  logic [INSTR_W-1:0] imem_instr;

  // IF/ID handshake
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc;

  modport master (
    output imem_addr, imem_re, id_valid, id_instr, id_pc,
    input  imem_instr, id_ready
  );

  modport slave (
    input  imem_addr, imem_re, id_valid, id_instr, id_pc,
    output imem_instr, id_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction
// memory and registers the returned word into IF/ID for decode. Supports
// branch/jump redirect with flush and stops fetching on a halt word.
`ifndef INSTR_MEM_WIDTH
`define INSTR_MEM_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module instr_fetch #(
  parameter int                PC_W       = 32,
  parameter int                ADDR_W     = `INSTR_MEM_WIDTH,
  parameter int                INSTR_W    = `INSTR_WIDTH,
  parameter logic [PC_W-1:0]   RESET_PC   = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(32'h00100073)
) (
  input  logic            clk,
  input  logic            rst,
  instr_fetch_if.master   bus,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic               halted_q, halted_d;
  logic [31:0]        fetch_count_q, fetch_count_d;

  logic running;
  logic slot_free;
  logic fire;
  logic is_halt;

  assign running   = (state_q == S_RUN);
  assign slot_free = ~id_valid_q | bus.id_ready;
  assign fire      = running & slot_free & ~redirect_valid;
  assign is_halt   = (bus.imem_instr == HALT_INSTR);

  assign bus.imem_addr = pc_q[ADDR_W-1:0];
  assign bus.imem_re   = running & ~redirect_valid;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_pc     = id_pc_q;
  assign halted        = halted_q;
  assign fetch_count   = fetch_count_q;

  // Next-state: FSM transitions, redirect flush, fetch into IF/ID, stall hold.
  always_comb begin
    // NOTE: every _d starts from its current value so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (fire && is_halt) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase

    if (redirect_valid) begin
      // Target is forced word aligned; fetch from it starts next cycle.
      pc_d       = redirect_pc & ~PC_W'(3);
      id_valid_d = 1'b0;
      state_d    = S_RUN;
    end else if (fire) begin
      id_instr_d    = bus.imem_instr;
      id_pc_d       = pc_q;
      id_valid_d    = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
      // A halt word is delivered but the PC parks on it.
      if (!is_halt) pc_d = pc_q + PC_W'(4);
    end else if (bus.id_ready) begin
      id_valid_d = 1'b0;
    end

    halted_d = (state_d == S_HALT);
  end

  // State register: synchronous reset overrides every other input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model of the fetch rules.
module tb_instr_fetch;

  localparam logic [31:0] HALT = 32'h00100073;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [31:0] fetch_count;

  logic        halt_en   = 1'b0;
  logic [31:0] halt_addr = '0;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_booting;
  logic        m_halted;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic [31:0] m_count;

  always #5 clk = ~clk;

  instr_fetch_if #(.PC_W(32), .ADDR_W(32), .INSTR_W(32)) bus ();

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  // Memory image: addi words tagged with their address, optional halt word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_en && a == halt_addr) return HALT;
    return {a[11:0], 20'h00013};
  endfunction

  assign bus.imem_instr = mem_word(bus.imem_addr);
  assign bus.id_ready   = id_ready;

  // Apply the fetch rules to the model for one clock edge.
  task automatic model_step();
    logic        active;
    logic        take;
    logic [31:0] word;
    if (rst) begin
      m_pc = 32'h0; m_booting = 1'b1; m_halted = 1'b0;
      m_valid = 1'b0; m_instr = '0; m_ipc = '0; m_count = '0;
    end else begin
      active = !m_booting && !m_halted;
      take   = active && (!m_valid || id_ready) && !redirect_valid;
      if (redirect_valid) begin
        m_pc     = {redirect_pc[31:2], 2'b00};
        m_valid  = 1'b0;
        m_halted = 1'b0;
      end else if (take) begin
        word    = mem_word(m_pc);
        m_valid = 1'b1;
        m_instr = word;
        m_ipc   = m_pc;
        m_count = m_count + 1;
        if (word == HALT) m_halted = 1'b1;
        else m_pc = m_pc + 4;
      end else if (id_ready) begin
        m_valid = 1'b0;
      end
      m_booting = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then settle past the edge.
  task automatic cycle(input logic r, input logic rdy, input logic rv,
                       input logic [31:0] rpc);
    rst = r; id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.id_valid); end
    total++; if (bus.id_instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", bus.id_instr); end
    total++; if (bus.id_pc !== 32'h0) begin bad++; $display("FAIL reset_idpc: got %h want 0", bus.id_pc); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL reset_count: got %h want 0", fetch_count); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
    total++; if (bus.imem_re !== 1'b0) begin bad++; $display("FAIL reset_re: got %b want 0", bus.imem_re); end
  endtask

  task automatic test_stream();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);  // boot cycle, no fetch
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL boot_valid: got %b want 0", bus.id_valid); end
    total++; if (bus.imem_re !== 1'b1) begin bad++; $display("FAIL boot_re: got %b want 1", bus.imem_re); end
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      total++; if (bus.id_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.id_valid); end
      total++; if (bus.id_pc !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc[%0d]: got %h want %h", i, bus.id_pc, 32'(4 * i)); end
      total++; if (bus.id_instr !== mem_word(32'(4 * i))) begin bad++; $display("FAIL stream_instr[%0d]: got %h want %h", i, bus.id_instr, mem_word(32'(4 * i))); end
      total++; if (fetch_count !== 32'(i + 1)) begin bad++; $display("FAIL stream_count[%0d]: got %0d want %0d", i, fetch_count, i + 1); end
    end
  endtask

  task automatic test_stall();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);  // fetch pc 0
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0) begin bad++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h want v=1 pc=0", i, bus.id_valid, bus.id_pc); end
      total++; if (bus.id_instr !== mem_word(32'h0)) begin bad++; $display("FAIL stall_instr[%0d]: got %h want %h", i, bus.id_instr, mem_word(32'h0)); end
      total++; if (bus.imem_addr !== 32'h4) begin bad++; $display("FAIL stall_addr[%0d]: got %h want 4", i, bus.imem_addr); end
    end
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (bus.id_pc !== 32'h4 || fetch_count !== 32'd2) begin bad++; $display("FAIL stall_release: got pc=%h cnt=%0d want pc=4 cnt=2", bus.id_pc, fetch_count); end
  endtask

  task automatic test_redirect();
    cycle(1'b0, 1'b0, 1'b0, 32'h0);  // hold pc 4 in IF/ID
    cycle(1'b0, 1'b0, 1'b1, 32'h22);
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got %b want 0", bus.id_valid); end
    total++; if (bus.imem_addr !== 32'h20) begin bad++; $display("FAIL redir_addr: got %h want 20", bus.imem_addr); end
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h20) begin bad++; $display("FAIL redir_fetch: got v=%b pc=%h want v=1 pc=20", bus.id_valid, bus.id_pc); end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    total++; if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", bus.id_valid); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rstmid_addr: got %h want 0", bus.imem_addr); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL rstmid_count: got %h want 0", fetch_count); end
    total++; if (bus.imem_re !== 1'b0) begin bad++; $display("FAIL rstmid_boot: got re=%b want 0", bus.imem_re); end
  endtask

  task automatic test_halt();
    halt_en = 1'b1; halt_addr = 32'hC;
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (bus.id_pc !== 32'hC || bus.id_instr !== HALT) begin bad++; $display("FAIL halt_deliver: got pc=%h instr=%h want pc=c instr=%h", bus.id_pc, bus.id_instr, HALT); end
    total++; if (halted !== 1'b1 || bus.imem_re !== 1'b0) begin bad++; $display("FAIL halt_state: got halted=%b re=%b want 1 0", halted, bus.imem_re); end
    total++; if (bus.imem_addr !== 32'hC) begin bad++; $display("FAIL halt_pc: got %h want c", bus.imem_addr); end
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (fetch_count !== 32'd4 || bus.id_valid !== 1'b0) begin bad++; $display("FAIL halt_nofire: got cnt=%0d v=%b want 4 0", fetch_count, bus.id_valid); end
    cycle(1'b0, 1'b1, 1'b1, 32'h0);
    total++; if (halted !== 1'b0 || bus.imem_addr !== 32'h0) begin bad++; $display("FAIL halt_resume: got halted=%b addr=%h want 0 0", halted, bus.imem_addr); end
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || fetch_count !== 32'd5) begin bad++; $display("FAIL halt_restart: got v=%b pc=%h cnt=%0d want 1 0 5", bus.id_valid, bus.id_pc, fetch_count); end
    halt_en = 1'b0;
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    total++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_align: got %h want fffffffc", bus.imem_addr); end
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (bus.id_pc !== 32'hFFFF_FFFC || bus.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_pc: got idpc=%h addr=%h want fffffffc 0", bus.id_pc, bus.imem_addr); end
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    total++; if (bus.id_pc !== 32'h0) begin bad++; $display("FAIL wrap_next: got %h want 0", bus.id_pc); end
  endtask

  task automatic test_random();
    logic        r, rdy, rv;
    logic [31:0] rpc;
    logic        exp_re;
    halt_en   = 1'b1;
    halt_addr = 32'(4 * $urandom_range(2, 15));
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 63) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = 32'($urandom_range(0, 70));
      cycle(r, rdy, rv, rpc);
      exp_re = !m_booting && !m_halted && !redirect_valid;
      total++;
      if (bus.id_valid !== m_valid || bus.id_pc !== m_ipc || bus.id_instr !== m_instr ||
          halted !== m_halted || fetch_count !== m_count ||
          bus.imem_addr !== m_pc || bus.imem_re !== exp_re) begin
        bad++;
        $display("FAIL random[%0d]: got v=%b pc=%h in=%h h=%b c=%0d a=%h re=%b want v=%b pc=%h in=%h h=%b c=%0d a=%h re=%b",
                 i, bus.id_valid, bus.id_pc, bus.id_instr, halted, fetch_count, bus.imem_addr, bus.imem_re,
                 m_valid, m_ipc, m_instr, m_halted, m_count, m_pc, exp_re);
      end
    end
    halt_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_reset_mid();
    test_halt();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
